// File: rtl/calc_pkg.sv
// calc_pkg -- shared definitions for the BCD calculator execution block.
//
// Contents:
//   OP_ADD..OP_DIV  opcodes accepted by calc_exec_ctrl; OP_KEY is the first
//                   code above the operation range (a keypad code, not an op)
//   ERR_*           values driven on the err output
//   calc_state_t    controller state encoding
//   NUM_DIGITS, BIN_W, MAX_VAL  operand geometry (6 BCD digits <-> 20 bits)
//   bcd_ok()        true when every nibble of a packed BCD word is 0..9

package calc_pkg;

  localparam logic [3:0] OP_ADD = 4'hA;
  localparam logic [3:0] OP_SUB = 4'hB;
  localparam logic [3:0] OP_MUL = 4'hC;
  localparam logic [3:0] OP_DIV = 4'hD;
  localparam logic [3:0] OP_KEY = 4'hE;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_OVF  = 2'd1;
  localparam logic [1:0] ERR_DIV0 = 2'd2;
  localparam logic [1:0] ERR_BAD  = 2'd3;

  localparam int NUM_DIGITS = 6;
  localparam int BIN_W      = 20;
  localparam logic [BIN_W-1:0] MAX_VAL = 20'd999999;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CONV_IN  = 3'd1,
    EXEC     = 3'd2,
    CONV_OUT = 3'd3,
    DONE     = 3'd4
  } calc_state_t;

  function automatic logic bcd_ok(input logic [4*NUM_DIGITS-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/calc_bin2bcd.sv
// calc_bin2bcd -- 20-bit binary to 6-digit packed BCD, double dabble.
//
// Ports:
//   CLK_1K  in   clock, rising edge
//   RST     in   asynchronous active-high reset
//   start   in   sampled on a rising edge; that edge loads bin and performs
//                the first of the 20 shift steps
//   bin     in   20-bit value to convert (must be <= 999999)
//   bcd     out  packed BCD result, valid once done has pulsed; held after
//   done    out  one-cycle pulse, raised by the edge that performs step 20
//                (19 edges after the start edge)

module calc_bin2bcd
  import calc_pkg::*;
(
  input  logic                    CLK_1K,
  input  logic                    RST,
  input  logic                    start,
  input  logic [BIN_W-1:0]        bin,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic                    done
);

  logic [BIN_W-1:0] shreg;
  logic [4:0]       step_cnt;
  logic             running;

  // One double-dabble step: add 3 to every digit >= 5, then shift left by
  // one bit taking the next binary bit in at the bottom.
  function automatic logic [4*NUM_DIGITS-1:0] dd_step(
    input logic [4*NUM_DIGITS-1:0] cur,
    input logic                    bit_in
  );
    logic [4*NUM_DIGITS-1:0] adj;
    adj = cur;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end
    return 24'({adj, bit_in});
  endfunction

  // The start edge already does step 1 (from an all-zero BCD register, so
  // no adjust is needed); the following 19 edges finish the conversion.
  always_ff @(posedge CLK_1K or posedge RST) begin
    if (RST) begin
      bcd      <= '0;
      shreg    <= '0;
      step_cnt <= '0;
      running  <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        bcd      <= dd_step('0, bin[BIN_W-1]);
        shreg    <= {bin[BIN_W-2:0], 1'b0};
        step_cnt <= 5'd1;
        running  <= 1'b1;
      end else if (running) begin
        bcd      <= dd_step(bcd, shreg[BIN_W-1]);
        shreg    <= {shreg[BIN_W-2:0], 1'b0};
        step_cnt <= step_cnt + 5'd1;
        if (step_cnt == 5'(BIN_W - 1)) begin
          running <= 1'b0;
          done    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/calc_exec_ctrl.sv
// calc_exec_ctrl -- executes one BCD add/sub/mul/div per start request.
//
// Ports:
//   CLK_1K        in   clock, all state changes on its rising edge
//   RST           in   asynchronous active-high reset
//   start         in   request, accepted only in IDLE
//   opcode        in   A add, B sub, C mul, D div (latched on acceptance)
//   num_reg1/2    in   operands A and B, six packed BCD digits
//   num_result    out  result magnitude in BCD (0 when err != 0)
//   neg           out  result negative (subtract with A < B)
//   err           out  0 none, 1 overflow, 2 divide by zero, 3 bad input
//   busy          out  high whenever not IDLE
//   result_valid  out  one-cycle pulse when the outputs above are updated
//
// Flow: IDLE -> CONV_IN (6 cycles BCD->binary) -> EXEC (1 or 20 cycles)
//       -> CONV_OUT (20 cycles, calc_bin2bcd) -> DONE -> IDLE.
// Input errors jump IDLE->DONE; add/mul overflow jumps EXEC->DONE.

module calc_exec_ctrl
  import calc_pkg::*;
(
  input  logic        CLK_1K,
  input  logic        RST,
  input  logic        start,
  input  logic [3:0]  opcode,
  input  logic [23:0] num_reg1,
  input  logic [23:0] num_reg2,
  output logic [23:0] num_result,
  output logic        neg,
  output logic [1:0]  err,
  output logic        busy,
  output logic        result_valid
);

  calc_state_t state;

  logic [3:0]       op_q;
  logic [23:0]      bcd_a, bcd_b;
  logic [BIN_W-1:0] bin_a, bin_b;
  logic [2:0]       digit_cnt;
  logic [4:0]       step_cnt;
  logic [1:0]       err_q;
  logic             neg_q;

  logic [2*BIN_W-1:0] mul_acc, mul_mcand;
  logic [BIN_W-1:0]   mul_mplier;
  logic [BIN_W-1:0]   div_rem, div_quot;

  logic [BIN_W-1:0]   conv_next_a, conv_next_b;
  logic [2*BIN_W-1:0] mul_next;
  logic [BIN_W:0]     div_shift;
  logic               div_ge;
  logic [BIN_W-1:0]   div_sub, div_next_rem, div_next_quot;
  logic [BIN_W:0]     add_sum;
  logic               a_lt_b;
  logic [BIN_W-1:0]   sub_mag;
  logic               op_ok;

  logic               exec_last, exec_ovf, exec_neg;
  logic [BIN_W-1:0]   exec_result;
  logic               bcd_start, bcd_done;
  logic [23:0]        bcd_out;

  // acc*10 + digit, with *10 built as (acc<<3)+(acc<<1).
  assign conv_next_a = {bin_a[16:0], 3'b0} + {bin_a[18:0], 1'b0} + {16'b0, bcd_a[23:20]};
  assign conv_next_b = {bin_b[16:0], 3'b0} + {bin_b[18:0], 1'b0} + {16'b0, bcd_b[23:20]};

  assign mul_next = mul_acc + (mul_mplier[0] ? mul_mcand : '0);

  // Restoring divide step: bring in the next dividend bit, subtract when it fits.
  assign div_shift     = {div_rem, div_quot[BIN_W-1]};
  assign div_ge        = div_shift >= {1'b0, bin_b};
  assign div_sub       = div_shift[BIN_W-1:0] - bin_b;
  assign div_next_rem  = div_ge ? div_sub : div_shift[BIN_W-1:0];
  assign div_next_quot = {div_quot[BIN_W-2:0], div_ge};

  assign add_sum = {1'b0, bin_a} + {1'b0, bin_b};
  assign a_lt_b  = bin_a < bin_b;
  assign sub_mag = a_lt_b ? (bin_b - bin_a) : (bin_a - bin_b);

  assign op_ok = (opcode >= OP_ADD) && (opcode < OP_KEY);

  // Result of the EXEC cycle that finishes the operation. For mul/div the
  // final step's combinational value is used so the binary->BCD converter
  // can start on that same edge instead of one cycle later.
  always_comb begin
    exec_last   = 1'b0;
    exec_ovf    = 1'b0;
    exec_neg    = 1'b0;
    exec_result = '0;
    case (op_q)
      OP_ADD: begin
        exec_last   = 1'b1;
        exec_ovf    = add_sum > {1'b0, MAX_VAL};
        exec_result = add_sum[BIN_W-1:0];
      end
      OP_SUB: begin
        exec_last   = 1'b1;
        exec_neg    = a_lt_b;
        exec_result = sub_mag;
      end
      OP_MUL: begin
        exec_last   = step_cnt == 5'(BIN_W - 1);
        exec_ovf    = mul_next > {20'b0, MAX_VAL};
        exec_result = mul_next[BIN_W-1:0];
      end
      OP_DIV: begin
        exec_last   = step_cnt == 5'(BIN_W - 1);
        exec_result = div_next_quot;
      end
      default: ;
    endcase
  end

  assign bcd_start = (state == EXEC) && exec_last && !exec_ovf;

  calc_bin2bcd u_bin2bcd (
    .CLK_1K (CLK_1K),
    .RST    (RST),
    .start  (bcd_start),
    .bin    (exec_result),
    .bcd    (bcd_out),
    .done   (bcd_done)
  );

  // Controller FSM and all registered outputs.
  always_ff @(posedge CLK_1K or posedge RST) begin
    if (RST) begin
      state        <= IDLE;
      op_q         <= '0;
      bcd_a        <= '0;
      bcd_b        <= '0;
      bin_a        <= '0;
      bin_b        <= '0;
      digit_cnt    <= '0;
      step_cnt     <= '0;
      err_q        <= ERR_NONE;
      neg_q        <= 1'b0;
      mul_acc      <= '0;
      mul_mcand    <= '0;
      mul_mplier   <= '0;
      div_rem      <= '0;
      div_quot     <= '0;
      num_result   <= '0;
      neg          <= 1'b0;
      err          <= ERR_NONE;
      busy         <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_q      <= opcode;
            bcd_a     <= num_reg1;
            bcd_b     <= num_reg2;
            bin_a     <= '0;
            bin_b     <= '0;
            digit_cnt <= '0;
            neg_q     <= 1'b0;
            busy      <= 1'b1;
            if (!bcd_ok(num_reg1) || !bcd_ok(num_reg2) || !op_ok) begin
              err_q <= ERR_BAD;
              state <= DONE;
            end else if (opcode == OP_DIV && num_reg2 == '0) begin
              err_q <= ERR_DIV0;
              state <= DONE;
            end else begin
              err_q <= ERR_NONE;
              state <= CONV_IN;
            end
          end
        end
        CONV_IN: begin
          bin_a     <= conv_next_a;
          bin_b     <= conv_next_b;
          bcd_a     <= {bcd_a[19:0], 4'h0};
          bcd_b     <= {bcd_b[19:0], 4'h0};
          digit_cnt <= digit_cnt + 3'd1;
          // Last digit: seed the iterative mul/div datapaths with the final
          // binary operands as they are being written.
          if (digit_cnt == 3'(NUM_DIGITS - 1)) begin
            state      <= EXEC;
            step_cnt   <= '0;
            mul_acc    <= '0;
            mul_mcand  <= {20'b0, conv_next_a};
            mul_mplier <= conv_next_b;
            div_rem    <= '0;
            div_quot   <= conv_next_a;
          end
        end
        EXEC: begin
          step_cnt   <= step_cnt + 5'd1;
          mul_acc    <= mul_next;
          mul_mcand  <= {mul_mcand[2*BIN_W-2:0], 1'b0};
          mul_mplier <= {1'b0, mul_mplier[BIN_W-1:1]};
          div_rem    <= div_next_rem;
          div_quot   <= div_next_quot;
          if (exec_last) begin
            neg_q <= exec_neg;
            if (exec_ovf) begin
              err_q <= ERR_OVF;
              state <= DONE;
            end else begin
              state <= CONV_OUT;
            end
          end
        end
        CONV_OUT: begin
          if (bcd_done) state <= DONE;
        end
        DONE: begin
          result_valid <= 1'b1;
          busy         <= 1'b0;
          err          <= err_q;
          if (err_q == ERR_NONE) begin
            num_result <= bcd_out;
            neg        <= neg_q;
          end else begin
            num_result <= '0;
            neg        <= 1'b0;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_exec_ctrl.sv
// tb_calc_exec_ctrl -- self-checking bench for calc_exec_ctrl.
// A behavioural model predicts busy/result_valid/num_result/neg/err from the
// arithmetic rules and latencies; a compare process checks every cycle, and
// directed operations pin literal results and result_valid edge numbers.

module tb_calc_exec_ctrl;

  logic        CLK_1K = 1'b0;
  logic        RST;
  logic        start;
  logic [3:0]  opcode;
  logic [23:0] num_reg1, num_reg2;
  logic [23:0] num_result;
  logic        neg;
  logic [1:0]  err;
  logic        busy;
  logic        result_valid;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  // Model state
  bit          m_busy  = 1'b0;
  int          m_count = 0;
  logic [23:0] m_pend_res = '0;
  bit          m_pend_neg = 1'b0;
  logic [1:0]  m_pend_err = '0;
  logic [23:0] m_res = '0;
  bit          m_neg = 1'b0;
  logic [1:0]  m_err = '0;
  bit          m_valid = 1'b0;

  calc_exec_ctrl dut (
    .CLK_1K       (CLK_1K),
    .RST          (RST),
    .start        (start),
    .opcode       (opcode),
    .num_reg1     (num_reg1),
    .num_reg2     (num_reg2),
    .num_result   (num_result),
    .neg          (neg),
    .err          (err),
    .busy         (busy),
    .result_valid (result_valid)
  );

  always #5 CLK_1K = ~CLK_1K;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
    end
  endtask

  function automatic bit isBcd(input logic [23:0] v);
    for (int i = 0; i < 6; i++) if (v[4*i +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic longint bcdToInt(input logic [23:0] v);
    longint n = 0;
    for (int i = 5; i >= 0; i--) n = n * 10 + longint'(v[4*i +: 4]);
    return n;
  endfunction

  function automatic logic [23:0] intToBcd(input longint n);
    logic [23:0] v = '0;
    longint r = n;
    for (int i = 0; i < 6; i++) begin
      v[4*i +: 4] = 4'(r % 10);
      r = r / 10;
    end
    return v;
  endfunction

  function automatic logic [23:0] randBcd(input int digits);
    logic [23:0] v = '0;
    for (int i = 0; i < digits; i++) v = {v[19:0], 4'($urandom_range(0, 9))};
    return v;
  endfunction

  // Predicts the outcome and the number of edges until result_valid.
  task automatic predict(input logic [3:0] op, input logic [23:0] a, input logic [23:0] b);
    longint av, bv, r;
    m_busy     = 1'b1;
    m_pend_res = '0;
    m_pend_neg = 1'b0;
    m_pend_err = 2'd0;
    if (!isBcd(a) || !isBcd(b) || op < 4'hA || op > 4'hD) begin
      m_pend_err = 2'd3;
      m_count    = 1;
    end else begin
      av = bcdToInt(a);
      bv = bcdToInt(b);
      if (op == 4'hD && bv == 0) begin
        m_pend_err = 2'd2;
        m_count    = 1;
      end else begin
        case (op)
          4'hA: begin
            r = av + bv;
            if (r > 999999) begin m_pend_err = 2'd1; m_count = 8; end
            else begin m_pend_res = intToBcd(r); m_count = 28; end
          end
          4'hB: begin
            m_count = 28;
            if (av < bv) begin m_pend_res = intToBcd(bv - av); m_pend_neg = 1'b1; end
            else m_pend_res = intToBcd(av - bv);
          end
          4'hC: begin
            r = av * bv;
            if (r > 999999) begin m_pend_err = 2'd1; m_count = 27; end
            else begin m_pend_res = intToBcd(r); m_count = 47; end
          end
          default: begin
            m_pend_res = intToBcd(av / bv);
            m_count    = 47;
          end
        endcase
      end
    end
  endtask

  // Behavioural model, advanced once per rising edge.
  always @(posedge CLK_1K or posedge RST) begin
    if (RST) begin
      m_busy  = 1'b0;
      m_count = 0;
      m_res   = '0;
      m_neg   = 1'b0;
      m_err   = '0;
      m_valid = 1'b0;
    end else begin
      m_valid = 1'b0;
      if (m_busy) begin
        m_count--;
        if (m_count == 0) begin
          m_valid = 1'b1;
          m_busy  = 1'b0;
          m_res   = m_pend_res;
          m_neg   = m_pend_neg;
          m_err   = m_pend_err;
        end
      end else if (start) begin
        predict(opcode, num_reg1, num_reg2);
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge CLK_1K) begin
    if (check_en && !RST) begin
      checkOutput("cyc_busy", 32'(busy), 32'(m_busy));
      checkOutput("cyc_result_valid", 32'(result_valid), 32'(m_valid));
      checkOutput("cyc_num_result", 32'(num_result), 32'(m_res));
      checkOutput("cyc_neg", 32'(neg), 32'(m_neg));
      checkOutput("cyc_err", 32'(err), 32'(m_err));
    end
  end

  // Issues one request, optionally with extra start pulses while busy, and
  // reports the edge (counted from the accepting edge) carrying result_valid.
  task automatic applyStimulus(input logic [3:0] op, input logic [23:0] a, input logic [23:0] b,
                               input int glitch_at, input bit noise, output int edge_no);
    bit seen = 1'b0;
    edge_no = 0;
    @(negedge CLK_1K);
    opcode   = op;
    num_reg1 = a;
    num_reg2 = b;
    start    = 1'b1;
    @(negedge CLK_1K);
    start = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      opcode   = 4'($urandom_range(0, 15));
      num_reg1 = 24'($urandom);
      num_reg2 = 24'($urandom);
      @(negedge CLK_1K);
      if (result_valid) begin
        edge_no = k;
        seen    = 1'b1;
        start   = 1'b0;
        break;
      end
      start = (k + 1 == glitch_at) || (noise && $urandom_range(0, 3) == 0);
    end
    start = 1'b0;
    checkOutput("result_valid_seen", 32'(seen), 32'd1);
  endtask

  task automatic expectResult(input string name, input logic [23:0] res, input bit n,
                              input logic [1:0] e, input int exp_edge, input int got_edge);
    checkOutput({name, "_num_result"}, 32'(num_result), 32'(res));
    checkOutput({name, "_neg"}, 32'(neg), 32'(n));
    checkOutput({name, "_err"}, 32'(err), 32'(e));
    checkOutput({name, "_edge"}, 32'(got_edge), 32'(exp_edge));
  endtask

  initial begin
    int got;
    int rv_seen;
    RST      = 1'b1;
    start    = 1'b0;
    opcode   = 4'h0;
    num_reg1 = '0;
    num_reg2 = '0;
    #12;
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_result_valid", 32'(result_valid), 32'd0);
    checkOutput("reset_num_result", 32'(num_result), 32'd0);
    checkOutput("reset_neg", 32'(neg), 32'd0);
    checkOutput("reset_err", 32'(err), 32'd0);
    @(negedge CLK_1K);
    RST      = 1'b0;
    check_en = 1'b1;

    $display("[TB] directed operations");
    applyStimulus(4'hA, 24'h000123, 24'h000877, 0, 1'b0, got);
    expectResult("add_carry", 24'h001000, 1'b0, 2'd0, 28, got);
    applyStimulus(4'hB, 24'h000005, 24'h000012, 0, 1'b0, got);
    expectResult("sub_neg", 24'h000007, 1'b1, 2'd0, 28, got);
    applyStimulus(4'hB, 24'h000500, 24'h000123, 0, 1'b0, got);
    expectResult("sub_pos", 24'h000377, 1'b0, 2'd0, 28, got);
    applyStimulus(4'hC, 24'h000999, 24'h000999, 5, 1'b0, got);
    expectResult("mul_glitch", 24'h998001, 1'b0, 2'd0, 47, got);
    applyStimulus(4'hC, 24'h001000, 24'h001000, 0, 1'b0, got);
    expectResult("mul_ovf", 24'h000000, 1'b0, 2'd1, 27, got);
    applyStimulus(4'hA, 24'h999999, 24'h000001, 0, 1'b0, got);
    expectResult("add_ovf", 24'h000000, 1'b0, 2'd1, 8, got);
    applyStimulus(4'hD, 24'h000100, 24'h000007, 0, 1'b0, got);
    expectResult("div", 24'h000014, 1'b0, 2'd0, 47, got);
    applyStimulus(4'hD, 24'h000100, 24'h000000, 0, 1'b0, got);
    expectResult("div_zero", 24'h000000, 1'b0, 2'd2, 1, got);
    applyStimulus(4'hA, 24'h0000A1, 24'h000001, 0, 1'b0, got);
    expectResult("bad_digit", 24'h000000, 1'b0, 2'd3, 1, got);
    applyStimulus(4'h3, 24'h000001, 24'h000001, 0, 1'b0, got);
    expectResult("bad_opcode", 24'h000000, 1'b0, 2'd3, 1, got);

    $display("[TB] reset during multiply");
    applyStimulus(4'hB, 24'h000005, 24'h000012, 0, 1'b0, got);
    @(negedge CLK_1K);
    opcode   = 4'hC;
    num_reg1 = 24'h000999;
    num_reg2 = 24'h000999;
    start    = 1'b1;
    @(negedge CLK_1K);
    start = 1'b0;
    repeat (9) @(negedge CLK_1K);
    checkOutput("busy_before_reset", 32'(busy), 32'd1);
    #2 RST = 1'b1;
    #1;
    checkOutput("midreset_busy", 32'(busy), 32'd0);
    checkOutput("midreset_result_valid", 32'(result_valid), 32'd0);
    checkOutput("midreset_num_result", 32'(num_result), 32'd0);
    checkOutput("midreset_neg", 32'(neg), 32'd0);
    checkOutput("midreset_err", 32'(err), 32'd0);
    @(negedge CLK_1K);
    @(negedge CLK_1K);
    #2 RST = 1'b0;
    rv_seen = 0;
    repeat (60) begin
      @(negedge CLK_1K);
      if (result_valid) rv_seen++;
    end
    checkOutput("no_valid_after_reset", 32'(rv_seen), 32'd0);
    applyStimulus(4'hA, 24'h000123, 24'h000877, 0, 1'b0, got);
    expectResult("add_after_reset", 24'h001000, 1'b0, 2'd0, 28, got);

    $display("[TB] randomized operations");
    for (int n = 0; n < 40; n++) begin
      logic [3:0]  op;
      logic [23:0] a, b;
      int          pos;
      op = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(0, 15))
                                         : 4'(32'hA + $urandom_range(0, 3));
      a = randBcd($urandom_range(0, 6));
      b = randBcd($urandom_range(0, 6));
      if ($urandom_range(0, 15) == 0) begin
        pos = $urandom_range(0, 5);
        a[4*pos +: 4] = 4'($urandom_range(10, 15));
      end
      if ($urandom_range(0, 9) == 0) b = '0;
      applyStimulus(op, a, b, 0, 1'b1, got);
    end

    repeat (3) @(negedge CLK_1K);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
